mp_mgmt_csr: RTL and testbench

- Responder end of the core management bus (mgmt_req/ack/rwn/adr/wen/txd/rxe/rxd); the core is the initiator.
- Owns the machine CSRs fed back to the core: mie, m32, mvec, mepc.
- Owns the interrupt pending/mask logic that produces exi/exi_code, and 8 perf counters driven by the core's perf strobes.
- Sits beside mp_core at top level. All outputs are registered except exi/exi_code.

---
 rtl/mp_mgmt_pkg.sv | 40 ++++
 rtl/mp_perf_cnt.sv | 47 ++++
 rtl/mp_mgmt_csr.sv | 228 ++++++++++++++++++++++
 tb/tb_mp_mgmt_csr.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mp_mgmt_pkg.sv
// ============================================================================
// mp_mgmt_pkg : shared offsets, FSM encoding and helpers for mp_mgmt_csr
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mp_mgmt_pkg;

  localparam logic [7:0] MSTATUS_OFS = 8'h00;
  localparam logic [7:0] MVEC_OFS    = 8'h04;
  localparam logic [7:0] MEPC_OFS    = 8'h08;
  localparam logic [7:0] MCAUSE_OFS  = 8'h0C;
  localparam logic [7:0] MASK_OFS    = 8'h10;
  localparam logic [7:0] PEND_OFS    = 8'h14;
  localparam logic [7:0] CNT0_OFS    = 8'h40;
  localparam logic [7:0] CNT7_OFS    = 8'h5C;

  localparam int MCAUSE_SWI  = 5;
  localparam int MCAUSE_W    = 6;
  localparam int MSTATUS_MIE = 0;
  localparam int MSTATUS_M32 = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_DONE   = 2'd3
  } mgmt_state_e;

  // Halfword-granular merge of write data into a current 32-bit value.
  function automatic logic [31:0] merge_half(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [1:0]  wen);
    merge_half = {wen[1] ? wd[31:16] : cur[31:16],
                  wen[0] ? wd[15:0]  : cur[15:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mp_perf_cnt.sv
// ============================================================================
// mp_perf_cnt : one wrapping perf counter with halfword-enabled load
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mp_perf_cnt
  import mp_mgmt_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [1:0]       wen_i,
  input  logic [31:0]      data_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      merged;

  // A load wins over a coincident increment; the increment is lost.
  always_comb begin
    merged = merge_half(32'(cnt_q), data_i, wen_i);
    cnt_d  = cnt_q;
    if (load_i) begin
      cnt_d = merged[CNT_W-1:0];
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mp_mgmt_csr.sv
// ============================================================================
// mp_mgmt_csr : management-bus responder holding machine CSRs, irq logic and
//               perf counters for mp_core
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mp_mgmt_csr
  import mp_mgmt_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h0000_F000,
  parameter int          IRQ_N     = 16,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0100,
  parameter logic        RESET_M32 = 1'b0
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             mgmt_req_i,
  input  logic             mgmt_rwn_i,
  input  logic [31:0]      mgmt_adr_i,
  input  logic [1:0]       mgmt_wen_i,
  input  logic [31:0]      mgmt_txd_i,
  output logic             mgmt_ack_o,
  output logic             mgmt_rxe_o,
  output logic [31:0]      mgmt_rxd_o,
  input  logic [IRQ_N-1:0] irq_i,
  input  logic             swi_i,
  input  logic             mie_set_i,
  input  logic [31:0]      pc_epc_i,
  input  logic [7:0]       perf_i,
  output logic             mie_o,
  output logic             m32_o,
  output logic [31:0]      mvec_o,
  output logic [31:0]      mepc_o,
  output logic             exi_o,
  output logic [4:0]       exi_code_o
);

  mgmt_state_e          state_q;
  logic                 ack_q, rxe_q;
  logic [31:0]          rxd_q;
  logic                 rwn_q;
  logic [31:2]          adr_q;
  logic [1:0]           wen_q;
  logic [31:0]          txd_q;

  logic                 mie_q, mie_d;
  logic                 m32_q, m32_d;
  logic [31:0]          mvec_q, mvec_d;
  logic [31:0]          mepc_q, mepc_d;
  logic [MCAUSE_W-1:0]  mcause_q, mcause_d;
  logic [IRQ_N-1:0]     mask_q, mask_d;

  logic [IRQ_N-1:0]     pend;
  logic                 trap;
  logic                 base_hit, cnt_sel, wr, cnt_wr, rd_hit;
  logic [7:0]           ofs;
  logic [31:0]          rd_data;
  logic [7:0]           cnt_load;
  logic [CNT_W-1:0]     cnt_val [8];
  logic                 unused_adr;

  assign unused_adr = ^mgmt_adr_i[1:0];

  assign pend  = irq_i & mask_q;
  assign exi_o = mie_q & (|pend);
  assign trap  = swi_i | exi_o;

  always_comb begin
    exi_code_o = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (pend[i]) exi_code_o = 5'(i);
    end
  end

  assign ofs      = {adr_q[7:2], 2'b00};
  assign base_hit = (adr_q[31:8] == BASE[31:8]);
  assign cnt_sel  = base_hit && (ofs >= CNT0_OFS) && (ofs <= CNT7_OFS);
  assign wr       = (state_q == ST_ACCESS) && !rwn_q && base_hit;
  assign cnt_wr   = wr && cnt_sel && (|wen_q);

  // Handshake FSM; the transaction fields are captured when req is first seen.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      rxe_q   <= 1'b0;
      rxd_q   <= '0;
      rwn_q   <= 1'b0;
      adr_q   <= '0;
      wen_q   <= '0;
      txd_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mgmt_req_i) begin
            state_q <= ST_ACCESS;
            rwn_q   <= mgmt_rwn_i;
            adr_q   <= mgmt_adr_i[31:2];
            wen_q   <= mgmt_wen_i;
            txd_q   <= mgmt_txd_i;
          end
        end
        ST_ACCESS: begin
          state_q <= ST_RESP;
          ack_q   <= 1'b1;
          rxe_q   <= rwn_q & rd_hit;
          rxd_q   <= (rwn_q & rd_hit) ? rd_data : '0;
        end
        ST_RESP: begin
          state_q <= ST_DONE;
          ack_q   <= 1'b0;
          rxe_q   <= 1'b0;
          rxd_q   <= '0;
        end
        ST_DONE: begin
          if (!mgmt_req_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_hit  = 1'b1;
    rd_data = '0;
    if (!base_hit) begin
      rd_hit = 1'b0;
    end else if (cnt_sel) begin
      rd_data = 32'(cnt_val[adr_q[4:2]]);
    end else begin
      case (ofs)
        MSTATUS_OFS: rd_data = {30'b0, m32_q, mie_q};
        MVEC_OFS:    rd_data = mvec_q;
        MEPC_OFS:    rd_data = mepc_q;
        MCAUSE_OFS:  rd_data = 32'(mcause_q);
        MASK_OFS:    rd_data = 32'(mask_q);
        PEND_OFS:    rd_data = 32'(pend);
        default:     rd_hit  = 1'b0;
      endcase
    end
  end

  // Bus write first, then mie_set, then trap: later assignments win.
  always_comb begin
    mie_d    = mie_q;
    m32_d    = m32_q;
    mvec_d   = mvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mask_d   = mask_q;
    if (wr) begin
      case (ofs)
        MSTATUS_OFS: begin
          if (wen_q[0]) begin
            mie_d = txd_q[MSTATUS_MIE];
            m32_d = txd_q[MSTATUS_M32];
          end
        end
        MVEC_OFS: mvec_d = merge_half(mvec_q, txd_q, wen_q);
        MEPC_OFS: mepc_d = merge_half(mepc_q, txd_q, wen_q);
        MASK_OFS: begin
          for (int i = 0; i < IRQ_N; i++) begin
            if (wen_q[i >= 16]) mask_d[i] = txd_q[i];
          end
        end
        default: ;
      endcase
    end
    if (mie_set_i) mie_d = 1'b1;
    if (trap) begin
      mie_d  = 1'b0;
      mepc_d = pc_epc_i;
      if (swi_i) begin
        mcause_d             = '0;
        mcause_d[MCAUSE_SWI] = 1'b1;
      end else begin
        mcause_d = {1'b0, exi_code_o};
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      mie_q    <= 1'b0;
      m32_q    <= RESET_M32;
      mvec_q   <= RESET_VEC;
      mepc_q   <= '0;
      mcause_q <= '0;
      mask_q   <= '0;
    end else begin
      mie_q    <= mie_d;
      m32_q    <= m32_d;
      mvec_q   <= mvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mask_q   <= mask_d;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_cnt
    assign cnt_load[g] = cnt_wr && (adr_q[4:2] == 3'(g));

    mp_perf_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i   (sys_clk_i),
      .rst_i   (sys_rst_i),
      .inc_i   (perf_i[g]),
      .load_i  (cnt_load[g]),
      .wen_i   (wen_q),
      .data_i  (txd_q),
      .value_o (cnt_val[g])
    );
  end

  assign mgmt_ack_o = ack_q;
  assign mgmt_rxe_o = rxe_q;
  assign mgmt_rxd_o = rxd_q;
  assign mie_o      = mie_q;
  assign m32_o      = m32_q;
  assign mvec_o     = mvec_q;
  assign mepc_o     = mepc_q;

endmodule

`default_nettype wire

// File: tb/tb_mp_mgmt_csr.sv
// ============================================================================
// tb_mp_mgmt_csr : directed self-checking bench for mp_mgmt_csr
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mp_mgmt_csr;

  logic        clk = 1'b0;
  logic        rst, req, rwn, swi, mie_set;
  logic [31:0] adr, txd, pc_epc;
  logic [1:0]  wen;
  logic [15:0] irq;
  logic [7:0]  perf;
  logic        ack, rxe, mie, m32, exi;
  logic [31:0] rxd, mvec, mepc;
  logic [4:0]  exi_code;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mp_mgmt_csr dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst),
    .mgmt_req_i (req),
    .mgmt_rwn_i (rwn),
    .mgmt_adr_i (adr),
    .mgmt_wen_i (wen),
    .mgmt_txd_i (txd),
    .mgmt_ack_o (ack),
    .mgmt_rxe_o (rxe),
    .mgmt_rxd_o (rxd),
    .irq_i      (irq),
    .swi_i      (swi),
    .mie_set_i  (mie_set),
    .pc_epc_i   (pc_epc),
    .perf_i     (perf),
    .mie_o      (mie),
    .m32_o      (m32),
    .mvec_o     (mvec),
    .mepc_o     (mepc),
    .exi_o      (exi),
    .exi_code_o (exi_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One bus transaction; pa is driven on perf only during the ACCESS cycle.
  task automatic mgmt(input logic r, input logic [31:0] a, input logic [1:0] w,
                      input logic [31:0] d, input logic [7:0] pa,
                      output logic [31:0] rd, output logic re, output int lat);
    @(negedge clk);
    req = 1'b1; rwn = r; adr = a; wen = w; txd = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) perf = pa;
    end while (!ack && lat < 20);
    perf = 8'h00;
    rd = rxd; re = rxe;
    req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        re;
  int          lat, acks;

  initial begin
    rst = 1'b1; req = 1'b0; rwn = 1'b0; adr = '0; wen = '0; txd = '0;
    irq = '0; swi = 1'b0; mie_set = 1'b0; pc_epc = '0; perf = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ack", 32'(ack), 32'd0);
    check("rst_mvec", mvec, 32'h0000_0100);
    check("rst_mie", 32'(mie), 32'd0);

    mgmt(1'b1, 32'h0000_F004, 2'b00, '0, 8'h00, rd, re, lat);
    check("rd_mvec_lat", 32'(lat), 32'd2);
    check("rd_mvec_rxe", 32'(re), 32'd1);
    check("rd_mvec", rd, 32'h0000_0100);
    mgmt(1'b1, 32'h0000_F000, 2'b00, '0, 8'h00, rd, re, lat);
    check("rd_mstatus", rd, 32'h0000_0000);

    mgmt(1'b0, 32'h0000_F008, 2'b01, 32'hDEAD_BEEF, 8'h00, rd, re, lat);
    check("wr_mepc_half", mepc, 32'h0000_BEEF);
    check("wr_rxe", 32'(re), 32'd0);
    mgmt(1'b1, 32'h0000_F008, 2'b00, '0, 8'h00, rd, re, lat);
    check("rd_mepc", rd, 32'h0000_BEEF);

    // req held high well past the ack
    @(negedge clk);
    req = 1'b1; rwn = 1'b1; adr = 32'h0000_F004;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("held_req_acks", 32'(acks), 32'd1);
    req = 1'b0;
    repeat (2) @(negedge clk);

    mgmt(1'b0, 32'h0000_F010, 2'b11, 32'h0000_0006, 8'h00, rd, re, lat);
    mgmt(1'b0, 32'h0000_F000, 2'b01, 32'h0000_0001, 8'h00, rd, re, lat);
    check("mie_wr", 32'(mie), 32'd1);
    check("m32_wr", 32'(m32), 32'd0);

    pc_epc = 32'h1234_5678;
    irq = 16'h000C;
    #1;
    check("exi_on", 32'(exi), 32'd1);
    check("exi_code", 32'(exi_code), 32'd2);
    @(negedge clk);
    check("trap_mie", 32'(mie), 32'd0);
    check("trap_mepc", mepc, 32'h1234_5678);
    check("trap_exi_off", 32'(exi), 32'd0);
    mgmt(1'b1, 32'h0000_F00C, 2'b00, '0, 8'h00, rd, re, lat);
    check("mcause_exi", rd, 32'h0000_0002);
    mgmt(1'b1, 32'h0000_F014, 2'b00, '0, 8'h00, rd, re, lat);
    check("pend", rd, 32'h0000_0004);
    irq = '0;

    mie_set = 1'b1;
    @(negedge clk);
    mie_set = 1'b0;
    check("mie_set", 32'(mie), 32'd1);

    irq = 16'h000C; swi = 1'b1; mie_set = 1'b1; pc_epc = 32'hCAFE_0000;
    @(negedge clk);
    irq = '0; swi = 1'b0; mie_set = 1'b0;
    check("swi_mie", 32'(mie), 32'd0);
    check("swi_mepc", mepc, 32'hCAFE_0000);
    mgmt(1'b1, 32'h0000_F00C, 2'b00, '0, 8'h00, rd, re, lat);
    check("mcause_swi", rd, 32'h0000_0020);

    mgmt(1'b0, 32'h0000_F00C, 2'b11, 32'h0000_001F, 8'h00, rd, re, lat);
    mgmt(1'b1, 32'h0000_F00C, 2'b00, '0, 8'h00, rd, re, lat);
    check("mcause_ro", rd, 32'h0000_0020);

    mgmt(1'b0, 32'h0000_F04C, 2'b11, 32'hFFFF_FFFF, 8'h00, rd, re, lat);
    perf = 8'h08;
    @(negedge clk);
    perf = 8'h00;
    mgmt(1'b1, 32'h0000_F04C, 2'b00, '0, 8'h00, rd, re, lat);
    check("cnt3_wrap", rd, 32'h0000_0000);
    mgmt(1'b0, 32'h0000_F04C, 2'b11, 32'h0000_1234, 8'h08, rd, re, lat);
    mgmt(1'b1, 32'h0000_F04C, 2'b00, '0, 8'h00, rd, re, lat);
    check("cnt3_wr_wins", rd, 32'h0000_1234);
    mgmt(1'b0, 32'h0000_F04C, 2'b10, 32'hABCD_0000, 8'h00, rd, re, lat);
    mgmt(1'b1, 32'h0000_F04C, 2'b00, '0, 8'h00, rd, re, lat);
    check("cnt3_half", rd, 32'hABCD_1234);
    mgmt(1'b1, 32'h0000_F040, 2'b00, '0, 8'h00, rd, re, lat);
    check("cnt0_idle", rd, 32'h0000_0000);

    mgmt(1'b1, 32'h0000_F030, 2'b00, '0, 8'h00, rd, re, lat);
    check("unmap_lat", 32'(lat), 32'd2);
    check("unmap_rxe", 32'(re), 32'd0);
    check("unmap_rxd", rd, 32'h0000_0000);
    mgmt(1'b1, 32'h0000_E004, 2'b00, '0, 8'h00, rd, re, lat);
    check("badbase_lat", 32'(lat), 32'd2);
    check("badbase_rxe", 32'(re), 32'd0);
    check("badbase_rxd", rd, 32'h0000_0000);
    mgmt(1'b0, 32'h0000_E004, 2'b11, 32'h7777_7777, 8'h00, rd, re, lat);
    check("badbase_wr", mvec, 32'h0000_0100);

    // reset lands while the write is in ACCESS; req stays high through it
    mie_set = 1'b1;
    @(negedge clk);
    mie_set = 1'b0;
    req = 1'b1; rwn = 1'b0; adr = 32'h0000_F004; wen = 2'b11; txd = 32'h5555_5555;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstacc_ack", 32'(ack), 32'd0);
    check("rstacc_mvec", mvec, 32'h0000_0100);
    check("rstacc_mepc", mepc, 32'h0000_0000);
    check("rstacc_mie", 32'(mie), 32'd0);
    check("rstacc_rxd", rxd, 32'h0000_0000);
    rst = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && lat < 20);
    check("rstacc_fresh_lat", 32'(lat), 32'd2);
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("rstacc_fresh_wr", mvec, 32'h5555_5555);
    mgmt(1'b1, 32'h0000_F04C, 2'b00, '0, 8'h00, rd, re, lat);
    check("rstacc_cnt3", rd, 32'h0000_0000);
    mgmt(1'b1, 32'h0000_F010, 2'b00, '0, 8'h00, rd, re, lat);
    check("rstacc_mask", rd, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
